// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin arbiter sharing one multiplier between two requesters
module mult_arbiter #(
   parameter int TIMEOUT_CYC = 20
) (
   input  logic        clk,
   input  logic        reset_L,
   input  logic        req0,
   input  logic        req1,
   input  logic [7:0]  A0,
   input  logic [7:0]  B0,
   input  logic [7:0]  A1,
   input  logic [7:0]  B1,
   output logic        ack0,
   output logic        ack1,
   output logic [15:0] result,
   output logic        err,
   output logic        busy,
   output logic        mult_start,
   output logic [7:0]  mult_A,
   output logic [7:0]  mult_B,
   input  logic        mult_done,
   input  logic [15:0] mult_out
);
   typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;
   localparam logic [7:0] LIM = 8'(TIMEOUT_CYC - 1);
   state_t state;
   logic owner, last, grant;
   logic [7:0] cnt;
   // on a tie the requester not served last wins
   assign grant = (req0 && req1) ? ~last : req1;
   assign busy = state != IDLE;
   always_ff @(posedge clk) begin
      if (!reset_L) begin
         state <= IDLE;
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         mult_start <= 1'b0;
         err <= 1'b0;
         result <= 16'h0000;
         mult_A <= 8'h00;
         mult_B <= 8'h00;
         cnt <= 8'h00;
         owner <= 1'b0;
         last <= 1'b1;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         mult_start <= 1'b0;
         case (state)
            IDLE: if (req0 || req1) begin
               owner <= grant;
               mult_A <= grant ? A1 : A0;
               mult_B <= grant ? B1 : B0;
               mult_start <= 1'b1;
               state <= START;
            end
            START: begin
               cnt <= 8'h00;
               state <= WAIT;
            end
            WAIT: if (mult_done) begin
               result <= mult_out;
               err <= 1'b0;
               ack0 <= ~owner;
               ack1 <= owner;
               state <= RESP;
            end else if (cnt == LIM) begin
               result <= 16'h0000;
               err <= 1'b1;
               ack0 <= ~owner;
               ack1 <= owner;
               state <= RESP;
            end else begin
               cnt <= cnt + 8'd1;
            end
            RESP: begin
               last <= owner;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: scoreboard bench with a behavioural multiplier of programmable delay
module tb_mult_arbiter;
   logic clk = 1'b0, reset_L = 1'b0, req0 = 1'b0, req1 = 1'b0;
   logic [7:0] A0 = 8'h00, B0 = 8'h00, A1 = 8'h00, B1 = 8'h00;
   logic ack0, ack1, err, busy, mult_start, mult_done;
   logic [15:0] result, mult_out;
   logic [7:0] mult_A, mult_B;
   int total = 0, bad = 0, starts = 0, delay = 0, k = 0;
   bit active = 1'b0, mdone = 1'b0, fdone = 1'b0;
   logic [17:0] sb[$];

   mult_arbiter #(.TIMEOUT_CYC(20)) dut (
      .clk(clk), .reset_L(reset_L), .req0(req0), .req1(req1),
      .A0(A0), .B0(B0), .A1(A1), .B1(B1),
      .ack0(ack0), .ack1(ack1), .result(result), .err(err), .busy(busy),
      .mult_start(mult_start), .mult_A(mult_A), .mult_B(mult_B),
      .mult_done(mult_done), .mult_out(mult_out)
   );

   always #5 clk = ~clk;
   assign mult_done = mdone | fdone;
   assign mult_out = {{8{mult_A[7]}}, mult_A} * {{8{mult_B[7]}}, mult_B};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // done rises on the delay-th WAIT cycle; delay 0 means never
   always @(negedge clk) begin
      if (mult_start) begin
         k = 0;
         active = 1'b1;
         mdone = 1'b0;
      end else if (active) begin
         if (!busy || ack0 || ack1) begin
            active = 1'b0;
            mdone = 1'b0;
         end else begin
            k++;
            mdone = (delay != 0) && (k >= delay);
         end
      end
   end

   always @(negedge clk) begin
      logic [17:0] e;
      if (mult_start) starts++;
      if (ack0 && ack1) chk("dual ack", 1, 0);
      if (ack0 || ack1) begin
         if (sb.size() == 0) chk("unexpected ack", 1, 0);
         else begin
            e = sb.pop_front();
            chk("owner", {31'd0, ack1}, {31'd0, e[17]});
            chk("result", {16'd0, result}, {16'd0, e[16:1]});
            chk("err", {31'd0, err}, {31'd0, e[0]});
         end
      end
   end

   task automatic do_reset();
      reset_L = 1'b0;
      repeat (2) @(negedge clk);
      reset_L = 1'b1;
   endtask

   task automatic run_op(input bit who, input logic [7:0] a, input logic [7:0] b, input int d,
                         input logic [15:0] er, input bit ee, input int lat, input bit chg);
      int n;
      bit seen;
      delay = d;
      sb.push_back({who, er, ee});
      if (who) begin req1 = 1'b1; A1 = a; B1 = b; end
      else begin req0 = 1'b1; A0 = a; B0 = b; end
      @(negedge clk);
      chk("start pulse", {31'd0, mult_start}, 1);
      chk("busy start", {31'd0, busy}, 1);
      chk("mult_A", {24'd0, mult_A}, {24'd0, a});
      chk("mult_B", {24'd0, mult_B}, {24'd0, b});
      if (chg) A0 = 8'h01;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 100) begin
         @(negedge clk);
         n++;
         seen = who ? ack1 : ack0;
         if (!seen) begin
            chk("mult_A hold", {24'd0, mult_A}, {24'd0, a});
            chk("no start in wait", {31'd0, mult_start}, 0);
         end
      end
      chk("latency", n, lat);
      if (who) req1 = 1'b0; else req0 = 1'b0;
   endtask

   task automatic wait_acks(input int n, input bit hold);
      int c = 0;
      for (int i = 0; i < 400 && c < n; i++) begin
         @(negedge clk);
         if (ack0) begin c++; if (!hold) req0 = 1'b0; end
         if (ack1) begin c++; if (!hold) req1 = 1'b0; end
      end
      chk("ack count", c, n);
      req0 = 1'b0;
      req1 = 1'b0;
   endtask

   initial begin
      int s0;
      @(negedge clk);
      @(negedge clk);
      chk("rst ack0", {31'd0, ack0}, 0);
      chk("rst ack1", {31'd0, ack1}, 0);
      chk("rst busy", {31'd0, busy}, 0);
      chk("rst start", {31'd0, mult_start}, 0);
      chk("rst err", {31'd0, err}, 0);
      chk("rst result", {16'd0, result}, 0);
      chk("rst mult_A", {24'd0, mult_A}, 0);
      chk("rst mult_B", {24'd0, mult_B}, 0);
      reset_L = 1'b1;
      @(negedge clk);
      run_op(1'b0, 8'h03, 8'hFE, 4, 16'hFFFA, 1'b0, 5, 1'b0);

      do_reset();
      s0 = starts;
      sb.push_back({1'b0, 16'h000A, 1'b0});
      sb.push_back({1'b1, 16'h000C, 1'b0});
      delay = 2;
      A0 = 8'd2; B0 = 8'd5; A1 = 8'hFD; B1 = 8'hFC;
      req0 = 1'b1; req1 = 1'b1;
      wait_acks(2, 1'b0);
      @(negedge clk);
      chk("start count", starts - s0, 2);

      A0 = 8'd5; B0 = 8'hF9; A1 = 8'h80; B1 = 8'h80;
      for (int i = 0; i < 2; i++) begin
         sb.push_back({1'b0, 16'hFFDD, 1'b0});
         sb.push_back({1'b1, 16'h4000, 1'b0});
      end
      req0 = 1'b1; req1 = 1'b1;
      wait_acks(4, 1'b1);
      @(negedge clk);

      run_op(1'b0, 8'd9, 8'd9, 0, 16'h0000, 1'b1, 21, 1'b0);
      @(negedge clk);
      run_op(1'b0, 8'd9, 8'd9, 20, 16'h0051, 1'b0, 21, 1'b0);
      @(negedge clk);
      run_op(1'b0, 8'h07, 8'h02, 3, 16'h000E, 1'b0, 4, 1'b1);
      @(negedge clk);

      delay = 0;
      A1 = 8'd2; B1 = 8'd2; req1 = 1'b1;
      repeat (3) @(negedge clk);
      chk("busy in wait", {31'd0, busy}, 1);
      reset_L = 1'b0;
      @(negedge clk);
      chk("rst wait busy", {31'd0, busy}, 0);
      chk("rst wait ack1", {31'd0, ack1}, 0);
      reset_L = 1'b1;
      req1 = 1'b0;
      fdone = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("late done busy", {31'd0, busy}, 0);
         chk("late done ack", {31'd0, ack0 | ack1}, 0);
      end
      fdone = 1'b0;
      @(negedge clk);
      chk("sb empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
